// File: rtl/frame_scanout_if.sv
// rtl/frame_scanout_if.sv - frame memory read port and VGA pin bundle
interface frame_scanout_if;
  logic [14:0] display_address;
  logic [23:0] pixel_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        blank_n;

  modport master (
    output display_address,
    input  pixel_data,
    output vga_r, vga_g, vga_b,
    output hsync, vsync, blank_n
  );

  modport slave (
    input  display_address,
    output pixel_data,
    input  vga_r, vga_g, vga_b,
    input  hsync, vsync, blank_n
  );
endinterface

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - VGA scanout of the stored frame with 4x4 upscale and bank swap
module frame_scanout #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_en,
  input  logic            processing_done,
  output logic            buf_sel,
  output logic            swap_ack,
  output logic            frame_start,
  frame_scanout_if.master vid
);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  COLS   = 8'(WIDTH);
  localparam logic [14:0] STRIDE = 15'(HEIGHT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } swap_state_t;

  swap_state_t state, state_next;
  logic [9:0]  h_cnt, v_cnt;
  logic        line_end, frame_end;
  logic        active, hs_now, vs_now;
  logic        active_d, hs_d, vs_d;
  logic [14:0] addr_next;
  logic [23:0] rgb;
  logic        done_q, done_rise, swap_point;

  always_comb begin
    line_end   = (h_cnt == H_LAST);
    frame_end  = line_end && (v_cnt == V_LAST);
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT) && (h_cnt[9:2] < COLS);
    hs_now     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_now     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    // Column-major storage: each stored column is HEIGHT words long.
    addr_next  = active ? (15'(v_cnt[9:2]) + 15'(h_cnt[9:2]) * STRIDE) : 15'd0;
    done_rise  = processing_done && !done_q;
    swap_point = pix_en && (h_cnt == 10'd0) && (v_cnt == V_ACT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        if (line_end) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Stage 1 issues the read; stage 2 lands the returned pixel with its delayed controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid.display_address <= 15'd0;
      active_d            <= 1'b0;
      hs_d                <= 1'b1;
      vs_d                <= 1'b1;
      rgb                 <= 24'd0;
      vid.blank_n         <= 1'b0;
      vid.hsync           <= 1'b1;
      vid.vsync           <= 1'b1;
    end else if (pix_en) begin
      vid.display_address <= addr_next;
      active_d            <= active;
      hs_d                <= hs_now;
      vs_d                <= vs_now;
      rgb                 <= active_d ? vid.pixel_data : 24'd0;
      vid.blank_n         <= active_d;
      vid.hsync           <= hs_d;
      vid.vsync           <= vs_d;
    end
  end

  assign {vid.vga_r, vid.vga_g, vid.vga_b} = rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      state    <= state_next;
      done_q   <= processing_done;
      buf_sel  <= buf_sel ^ (state == SWAP);
      swap_ack <= (state == SWAP);
    end
  end

  // Edges seen while already PENDING merge; an edge during SWAP re-arms for the next frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (done_rise) state_next = PENDING;
      PENDING: if (swap_point) state_next = SWAP;
      SWAP:    state_next = done_rise ? PENDING : IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - self-checking bench for frame_scanout on a reduced display geometry
module tb_frame_scanout;
  localparam int WIDTH    = 16;
  localparam int HEIGHT   = 8;
  localparam int H_ACTIVE = 64;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 32;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int LINE     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int LINES    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = LINE * LINES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  logic processing_done = 1'b0;
  logic buf_sel, swap_ack, frame_start;

  frame_scanout_if vid ();

  frame_scanout #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .processing_done(processing_done),
    .buf_sel(buf_sel),
    .swap_ack(swap_ack),
    .frame_start(frame_start),
    .vid(vid)
  );

  always #5 clk = ~clk;

  // Frame memory whose content equals its address, one clock read latency.
  always @(posedge clk) vid.pixel_data <= {9'd0, vid.display_address};

  int tick_n = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) tick_n <= 0;
    else if (pix_en) tick_n <= tick_n + 1;
  end

  int swap_count = 0;
  int swap_at = -1;
  int fs_count = 0;
  int fs_tick = -1;
  always @(negedge clk) begin
    if (swap_ack === 1'b1) begin
      swap_count = swap_count + 1;
      swap_at = tick_n;
    end
    if (frame_start === 1'b1) begin
      fs_count = fs_count + 1;
      fs_tick = tick_n;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d tick=%0d", name, act, exp, tick_n);
    end
  endtask

  function automatic int hpos(int p); return p % LINE; endfunction
  function automatic int vpos(int p); return (p / LINE) % LINES; endfunction
  function automatic bit act_at(int p);
    return (hpos(p) < H_ACTIVE) && (vpos(p) < V_ACTIVE);
  endfunction
  function automatic int addr_at(int p);
    return act_at(p) ? (vpos(p) / 4 + (hpos(p) / 4) * HEIGHT) : 0;
  endfunction
  function automatic bit hs_at(int p);
    return !(hpos(p) >= H_ACTIVE + H_FP && hpos(p) < H_ACTIVE + H_FP + H_SYNC);
  endfunction
  function automatic bit vs_at(int p);
    return !(vpos(p) >= V_ACTIVE + V_FP && vpos(p) < V_ACTIVE + V_FP + V_SYNC);
  endfunction

  // After n ticks the address reflects tick n-1 and the pins reflect tick n-2.
  task automatic check_model();
    int n;
    int p;
    n = tick_n;
    chk("addr", vid.display_address, (n == 0) ? 0 : addr_at(n - 1));
    chk("frame_start", frame_start, (n > 0 && n % FRAME == 0) ? 1 : 0);
    if (n < 2) begin
      chk("blank_n", vid.blank_n, 0);
      chk("hsync", vid.hsync, 1);
      chk("vsync", vid.vsync, 1);
      chk("rgb", {vid.vga_r, vid.vga_g, vid.vga_b}, 0);
    end else begin
      p = n - 2;
      chk("blank_n", vid.blank_n, act_at(p));
      chk("hsync", vid.hsync, hs_at(p));
      chk("vsync", vid.vsync, vs_at(p));
      chk("rgb", {vid.vga_r, vid.vga_g, vid.vga_b}, addr_at(p));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, vid.display_address, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
    chk({tag, "_swap_ack"}, swap_ack, 0);
    chk({tag, "_rgb"}, {vid.vga_r, vid.vga_g, vid.vga_b}, 0);
    chk({tag, "_hsync"}, vid.hsync, 1);
    chk({tag, "_vsync"}, vid.vsync, 1);
    chk({tag, "_blank_n"}, vid.blank_n, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic do_tick(input int gap);
    @(negedge clk) pix_en = 1'b1;
    @(negedge clk) pix_en = 1'b0;
    check_model();
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (tick_n < target) do_tick(int'($urandom_range(1, 2)));
  endtask

  task automatic pulse_done();
    @(negedge clk) processing_done = 1'b1;
    @(negedge clk);
    @(negedge clk) processing_done = 1'b0;
  endtask

  typedef struct {
    int h;
    int v;
    int addr;
    bit blank;
    bit hs;
    bit vs;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tick=%0d", tick_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int base;
    logic [31:0] s_addr, s_rgb;
    logic s_hs, s_vs, s_blank;

    tbl[0]  = '{0, 0, 0, 1, 1, 1};
    tbl[1]  = '{3, 0, 0, 1, 1, 1};
    tbl[2]  = '{4, 0, 8, 1, 1, 1};
    tbl[3]  = '{7, 0, 8, 1, 1, 1};
    tbl[4]  = '{8, 0, 16, 1, 1, 1};
    tbl[5]  = '{63, 0, 120, 1, 1, 1};
    tbl[6]  = '{64, 0, 0, 0, 1, 1};
    tbl[7]  = '{68, 0, 0, 0, 0, 1};
    tbl[8]  = '{75, 0, 0, 0, 0, 1};
    tbl[9]  = '{76, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 4, 1, 1, 1, 1};
    tbl[11] = '{63, 31, 127, 1, 1, 1};
    tbl[12] = '{0, 34, 0, 0, 1, 0};
    tbl[13] = '{79, 35, 0, 0, 1, 0};
    tbl[14] = '{0, 36, 0, 0, 1, 1};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset("post_reset_idle");

    for (int i = 0; i < 15; i++) begin
      p = tbl[i].v * LINE + tbl[i].h;
      while (tick_n < p + 1) do_tick(1);
      chk($sformatf("tbl%0d_addr", i), vid.display_address, tbl[i].addr);
      do_tick(1);
      chk($sformatf("tbl%0d_blank_n", i), vid.blank_n, tbl[i].blank);
      chk($sformatf("tbl%0d_hsync", i), vid.hsync, tbl[i].hs);
      chk($sformatf("tbl%0d_vsync", i), vid.vsync, tbl[i].vs);
      chk($sformatf("tbl%0d_rgb", i), {vid.vga_r, vid.vga_g, vid.vga_b},
          tbl[i].blank ? tbl[i].addr : 0);
    end
    while (tick_n < FRAME + 2) do_tick(1);
    chk("fs_count", fs_count, 1);
    chk("fs_tick", fs_tick, FRAME);

    repeat (1000) do_tick(int'($urandom_range(1, 3)));

    while (tick_n % LINE != 20) do_tick(1);
    s_addr  = 32'(vid.display_address);
    s_rgb   = 32'({vid.vga_r, vid.vga_g, vid.vga_b});
    s_hs    = vid.hsync;
    s_vs    = vid.vsync;
    s_blank = vid.blank_n;
    repeat (50) @(negedge clk);
    chk("hold_addr", vid.display_address, s_addr);
    chk("hold_rgb", {vid.vga_r, vid.vga_g, vid.vga_b}, s_rgb);
    chk("hold_hsync", vid.hsync, s_hs);
    chk("hold_vsync", vid.vsync, s_vs);
    chk("hold_blank_n", vid.blank_n, s_blank);
    do_tick(1);

    base = (tick_n / FRAME + 1) * FRAME;
    run_to(base + 10 * LINE);
    pulse_done();
    run_to(base + 20 * LINE);
    pulse_done();
    run_to(base + V_ACTIVE * LINE + 3);
    chk("swap1_count", swap_count, 1);
    chk("swap1_tick", swap_at, base + V_ACTIVE * LINE + 1);
    chk("swap1_buf_sel", buf_sel, 1);

    run_to(base + FRAME + 5 * LINE);
    pulse_done();
    run_to(base + FRAME + 20 * LINE + 30);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    check_reset("rst_next_clk");
    rst = 1'b1;

    run_to(V_ACTIVE * LINE + 3);
    chk("lost_swap_count", swap_count, 1);
    chk("lost_swap_buf_sel", buf_sel, 0);

    @(negedge clk) processing_done = 1'b1;
    run_to(3 * FRAME + V_ACTIVE * LINE + 3);
    processing_done = 1'b0;
    chk("held_swap_count", swap_count, 2);
    chk("held_swap_tick", swap_at, FRAME + V_ACTIVE * LINE + 1);
    chk("held_buf_sel", buf_sel, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
